nios_debug_ocimem_arbiter: RTL and testbench
============================================

Name: nios_debug_ocimem_arbiter

Overview:
Sysclk-domain controller that shares the single-port OCI debug RAM between two requesters:
- the JTAG debug slave, via the take_action/jdo strobes;
- the CPU's Avalon debug_mem slave port.
It owns the auto-incrementing monitor address register (MonAReg) and the monitor data register (MonDReg) read back over JTAG. It sequences RAM reads (1-cycle RAM latency) and writes, and flags JTAG command overruns.

Parameters:
ADDR_W, 8, OCI RAM word-address width (RAM depth 2^ADDR_W x 32)
DATA_W, 32, data width; fixed at 32, jdo packing depends on it

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
jdo  in  38  JTAG data from sysclk side of debug slave
take_action_ocimem_a  in  1  1-cycle strobe: load address, optional read
take_action_ocimem_b  in  1  1-cycle strobe: write at MonAReg
take_no_action_ocimem_a  in  1  1-cycle strobe: read at MonAReg
av_address  in  ADDR_W  Avalon word address
av_read  in  1  Avalon read request
av_write  in  1  Avalon write request
av_writedata  in  32  Avalon write data
av_byteenable  in  4  Avalon byte enables
av_debugaccess  in  1  write permitted only when high
av_readdata  out  32  Avalon read data
av_waitrequest  out  1  Avalon stall
ram_addr  out  ADDR_W  RAM address
ram_wren  out  1  RAM write enable
ram_byteenable  out  4  RAM byte enables
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid 1 cycle after address
MonDReg  out  32  JTAG read-back data
MonAReg  out  ADDR_W  current JTAG address
jtag_busy  out  1  JTAG command pending or in flight
jtag_overrun  out  1  sticky: JTAG strobe arrived while a command was pending

Behaviour:
- Reset values: MonDReg=0, MonAReg=0, av_readdata=0, jtag_busy=0, jtag_overrun=0, ram_wren=0, state IDLE.
- av_waitrequest=1 at reset and whenever the Avalon request is not being completed.
- JTAG decode (latched into a 1-deep pending slot):
  - ocimem_a: MonAReg <= jdo[ADDR_W+1:2] immediately; if jdo[35]=1, pend READ.
  - ocimem_b: pend WRITE with data jdo[34:3], byteenable 4'hF.
  - no_action_ocimem_a: pend READ.
- Overrun: any strobe while pending or in flight sets jtag_overrun (sticky until reset). The strobe is dropped; an address load from ocimem_a still applies.
- jtag_busy = pending | state==JRD_WAIT.
- FSM states IDLE, JRD_WAIT, ARD_WAIT. Arbitration happens only in IDLE.
- JTAG has priority when both sides request (see the optional feature).
- JTAG WRITE grant (IDLE):
  - ram_addr=MonAReg, ram_wren=1 for that cycle.
  - Next cycle MonAReg+1; pending cleared; stay IDLE.
- JTAG READ grant (IDLE):
  - ram_addr=MonAReg; go to JRD_WAIT.
  - In JRD_WAIT: MonDReg<=ram_rdata, MonAReg+1, pending cleared, back to IDLE.
- Avalon write grant (IDLE):
  - ram_addr=av_address, ram_wren=av_debugaccess, av_waitrequest=0 combinationally in that cycle.
  - A write without debugaccess completes but does not modify the RAM.
- Avalon read grant (IDLE):
  - ram_addr=av_address; go to ARD_WAIT.
  - In ARD_WAIT: av_readdata=ram_rdata, av_waitrequest=0 for exactly one cycle, then IDLE.
  - Read latency is 2 cycles minimum.
- av_read and av_write together: treat as a write.
- Addresses wrap: MonAReg = 2^ADDR_W-1 increments to 0.
- A JTAG strobe in the same cycle as a JTAG grant from the previous pending command is an overrun.
- Reset mid-read aborts the read: no waitrequest drop, no MonDReg update.
- ram_wren is never asserted outside IDLE.

Optional Feature:
OCIMEM_RR_EN
- Defined: round-robin arbitration. A last-grant flag (reset = Avalon) gives the next contested IDLE cycle to the other requester. Uncontested requests are granted immediately.
- Undefined: fixed JTAG priority; Avalon can starve while JTAG keeps issuing commands.

Test Plan:
- Reset, then ocimem_a with jdo[9:2]=8'h10, jdo[35]=0; then ocimem_b with jdo[34:3]=32'hDEADBEEF -> RAM[0x10]=DEADBEEF, MonAReg=0x11, jtag_overrun=0.
- ocimem_a addr 0x10 with jdo[35]=1 -> two cycles later MonDReg=DEADBEEF, MonAReg=0x11; no_action_ocimem_a -> MonDReg=RAM[0x11], MonAReg=0x12.
- MonAReg=0xFF, then no_action_ocimem_a -> reads RAM[0xFF], MonAReg=0x00.
- Avalon write 0x20/32'h12345678 with debugaccess=1 -> waitrequest low in the same cycle. Avalon read 0x20 -> waitrequest low on cycle 2, readdata=12345678. Repeat write 0x20/32'h0 with debugaccess=0 -> RAM unchanged.
- JTAG read and Avalon read in the same cycle:
  - Without OCIMEM_RR_EN: JTAG completes first, Avalon completes at cycle 4.
  - With OCIMEM_RR_EN after a prior JTAG grant: Avalon goes first.
- Two no_action_ocimem_a strobes 1 cycle apart -> jtag_overrun=1, only one increment of MonAReg. Assert reset_n=0 during ARD_WAIT -> av_waitrequest=1, all outputs at reset values.

Source files
------------

// File: rtl/nios_debug_ocimem_arbiter.sv
// nios_debug_ocimem_arbiter
// Shares the single-port OCI debug RAM between the JTAG debug slave
// (take_action/jdo strobes) and the CPU's Avalon debug_mem slave port.
// It owns the auto-incrementing monitor address register (MonAReg) and the
// monitor data register (MonDReg). It also flags JTAG command overruns.
//
// Build option:
//   OCIMEM_RR_EN - when defined, contested IDLE cycles alternate between
//                  requesters using a last-grant flag.
//                  When undefined, JTAG always wins a contested cycle.
module nios_debug_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    input  logic [3:0]        av_byteenable,
    input  logic              av_debugaccess,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteenable,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              jtag_busy,
    output logic              jtag_overrun
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        JRD_WAIT = 2'd1,
        ARD_WAIT = 2'd2
    } state_t;

    state_t            state_r;
    logic              ready_r;       // low from reset until the first clock after it
    logic              pend_valid_r;
    logic              pend_write_r;
    logic [DATA_W-1:0] pend_data_r;
    logic [ADDR_W-1:0] mon_a_r;
    logic [DATA_W-1:0] mon_d_r;
    logic [DATA_W-1:0] rdata_hold_r;
    logic              overrun_r;

    logic              av_req_s;
    logic              jtag_busy_s;
    logic              strobe_any_s;
    logic              pend_set_s;
    logic              grant_jtag_s;
    logic              grant_av_s;
    logic              unused_s;

    assign av_req_s     = av_read | av_write;
    assign jtag_busy_s  = pend_valid_r | (state_r == JRD_WAIT);
    assign strobe_any_s = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    // ocimem_a without the read bit only loads the address and never pends a command.
    assign pend_set_s   = ~jtag_busy_s & (take_action_ocimem_b | take_no_action_ocimem_a |
                                          (take_action_ocimem_a & jdo[35]));
    assign unused_s     = ^{jdo[37:36], jdo[1:0]};

`ifdef OCIMEM_RR_EN
    logic last_jtag_r;  // 1 = JTAG received the most recent grant

    // Track which requester won the most recent grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_jtag_r <= 1'b0;
        end else if (grant_jtag_s) begin
            last_jtag_r <= 1'b1;
        end else if (grant_av_s) begin
            last_jtag_r <= 1'b0;
        end
    end

    // Round-robin arbitration; only an IDLE cycle can grant.
    always_comb begin
        grant_jtag_s = 1'b0;
        grant_av_s   = 1'b0;
        if (ready_r && (state_r == IDLE)) begin
            if (pend_valid_r && av_req_s) begin
                if (last_jtag_r) begin
                    grant_av_s = 1'b1;
                end else begin
                    grant_jtag_s = 1'b1;
                end
            end else if (pend_valid_r) begin
                grant_jtag_s = 1'b1;
            end else if (av_req_s) begin
                grant_av_s = 1'b1;
            end else begin
                grant_jtag_s = 1'b0;
            end
        end else begin
            grant_av_s = 1'b0;
        end
    end
`else
    // Fixed-priority arbitration; a pending JTAG command always wins.
    always_comb begin
        grant_jtag_s = 1'b0;
        grant_av_s   = 1'b0;
        if (ready_r && (state_r == IDLE)) begin
            if (pend_valid_r) begin
                grant_jtag_s = 1'b1;
            end else if (av_req_s) begin
                grant_av_s = 1'b1;
            end else begin
                grant_jtag_s = 1'b0;
            end
        end else begin
            grant_av_s = 1'b0;
        end
    end
`endif

    // Steer the RAM port and the Avalon handshake from the current grant.
    // A simultaneous read and write is served as a write.
    always_comb begin
        ram_addr       = mon_a_r;
        ram_wdata      = pend_data_r;
        ram_byteenable = 4'hF;
        if (grant_av_s) begin
            ram_addr       = av_address;
            ram_wdata      = av_writedata;
            ram_byteenable = av_byteenable;
        end else begin
            ram_addr       = mon_a_r;
        end
        ram_wren       = (grant_jtag_s & pend_write_r) | (grant_av_s & av_write & av_debugaccess);
        av_waitrequest = ~((grant_av_s & av_write) | (state_r == ARD_WAIT));
        if (state_r == ARD_WAIT) begin
            av_readdata = ram_rdata;
        end else begin
            av_readdata = rdata_hold_r;
        end
    end

    // Main sequencer: JTAG command slot, monitor registers and access FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            ready_r      <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_write_r <= 1'b0;
            pend_data_r  <= {DATA_W{1'b0}};
            mon_a_r      <= {ADDR_W{1'b0}};
            mon_d_r      <= {DATA_W{1'b0}};
            rdata_hold_r <= {DATA_W{1'b0}};
            overrun_r    <= 1'b0;
        end else begin
            ready_r <= 1'b1;
            case (state_r)
                IDLE: begin
                    if (grant_jtag_s && pend_write_r) begin
                        mon_a_r      <= mon_a_r + ADDR_W'(1);
                        pend_valid_r <= 1'b0;
                    end else if (grant_jtag_s) begin
                        state_r <= JRD_WAIT;
                    end else if (grant_av_s && !av_write) begin
                        state_r <= ARD_WAIT;
                    end
                end
                JRD_WAIT: begin
                    mon_d_r      <= ram_rdata;
                    mon_a_r      <= mon_a_r + ADDR_W'(1);
                    pend_valid_r <= 1'b0;
                    state_r      <= IDLE;
                end
                ARD_WAIT: begin
                    rdata_hold_r <= ram_rdata;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
            // An address load applies even when its command is dropped as an overrun.
            if (take_action_ocimem_a) begin
                mon_a_r <= jdo[ADDR_W+1:2];
            end
            if (pend_set_s) begin
                pend_valid_r <= 1'b1;
                pend_write_r <= take_action_ocimem_b;
                pend_data_r  <= jdo[DATA_W+2:3];
            end
            if (strobe_any_s && jtag_busy_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign MonDReg      = mon_d_r;
    assign MonAReg      = mon_a_r;
    assign jtag_busy    = jtag_busy_s;
    assign jtag_overrun = overrun_r;

endmodule

// File: tb/tb_nios_debug_ocimem_arbiter.sv
// Directed testbench for nios_debug_ocimem_arbiter with a behavioural
// 256x32 synchronous RAM (1-cycle read latency, byte-enabled writes).
module tb_nios_debug_ocimem_arbiter;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [7:0]  av_address;
    logic        av_read;
    logic        av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic        av_debugaccess;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        jtag_busy;
    logic        jtag_overrun;

    int tests_run;
    int tests_failed;

    logic [31:0] mem [0:255];

    nios_debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_byteenable           (av_byteenable),
        .av_debugaccess          (av_debugaccess),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_byteenable          (ram_byteenable),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM.
    always @(posedge clk) begin
        if (ram_wren) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_byteenable[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Avalon write; completion is expected in the request cycle.
    task automatic av_wr(input logic [7:0] addr, input logic [31:0] data, input logic dbg);
        av_address = addr; av_writedata = data; av_debugaccess = dbg;
        av_byteenable = 4'hF; av_write = 1'b1;
        #1;
        tests_run++;
        if (av_waitrequest !== 1'b0) begin
            tests_failed++; $display("FAIL av_wr_wait[%h]: got %b exp 0", addr, av_waitrequest);
        end
        tests_run++;
        if (ram_wren !== dbg || ram_addr !== addr) begin
            tests_failed++; $display("FAIL av_wr_ram[%h]: wren %b addr %h exp wren %b addr %h", addr, ram_wren, ram_addr, dbg, addr);
        end
        tick();
        av_write = 1'b0; av_debugaccess = 1'b0;
    endtask

    // Avalon read; waits a bounded number of cycles for waitrequest to drop.
    task automatic av_rd(input logic [7:0] addr, input logic [31:0] exp_data, input int exp_lat);
        int lat;
        logic done;
        logic [31:0] got;
        lat = 0; done = 1'b0; got = 32'h0;
        av_address = addr; av_read = 1'b1;
        while (!done && lat < 20) begin
            lat++;
            #1;
            if (!av_waitrequest) begin
                done = 1'b1; got = av_readdata;
            end
            tick();
        end
        av_read = 1'b0;
        tests_run++;
        if (!done || lat !== exp_lat) begin
            tests_failed++; $display("FAIL av_rd_lat[%h]: got %0d done %b exp %0d", addr, lat, done, exp_lat);
        end
        tests_run++;
        if (got !== exp_data) begin
            tests_failed++; $display("FAIL av_rd_data[%h]: got %h exp %h", addr, got, exp_data);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        tests_run++;
        if (MonDReg !== 32'h0 || MonAReg !== 8'h0 || av_readdata !== 32'h0) begin
            tests_failed++; $display("FAIL reset_regs: MonDReg %h MonAReg %h readdata %h exp 0", MonDReg, MonAReg, av_readdata);
        end
        tests_run++;
        if (jtag_busy !== 1'b0 || jtag_overrun !== 1'b0 || ram_wren !== 1'b0) begin
            tests_failed++; $display("FAIL reset_flags: busy %b overrun %b wren %b exp 0", jtag_busy, jtag_overrun, ram_wren);
        end
        tests_run++;
        if (av_waitrequest !== 1'b1) begin
            tests_failed++; $display("FAIL reset_wait: got %b exp 1", av_waitrequest);
        end
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_avalon();
        av_wr(8'h11, 32'hCAFEF00D, 1'b1);
        av_wr(8'hFF, 32'h0BADF00D, 1'b1);
        av_wr(8'h20, 32'h12345678, 1'b1);
        av_rd(8'h20, 32'h12345678, 2);
        av_wr(8'h20, 32'h00000000, 1'b0);
        av_rd(8'h20, 32'h12345678, 2);
        tests_run++;
        if (mem[8'h20] !== 32'h12345678) begin
            tests_failed++; $display("FAIL av_nodebug: ram %h exp %h", mem[8'h20], 32'h12345678);
        end
    endtask

    task automatic test_jtag_write();
        jdo = 38'h0; jdo[9:2] = 8'h10; take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        tests_run++;
        if (MonAReg !== 8'h10 || jtag_busy !== 1'b0) begin
            tests_failed++; $display("FAIL jwr_load: MonAReg %h busy %b exp 10 0", MonAReg, jtag_busy);
        end
        jdo = 38'h0; jdo[34:3] = 32'hDEADBEEF; take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        #1;
        tests_run++;
        if (ram_wren !== 1'b1 || ram_addr !== 8'h10 || ram_wdata !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL jwr_grant: wren %b addr %h data %h exp 1 10 deadbeef", ram_wren, ram_addr, ram_wdata);
        end
        tick();
        tests_run++;
        if (mem[8'h10] !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL jwr_ram: got %h exp deadbeef", mem[8'h10]);
        end
        tests_run++;
        if (MonAReg !== 8'h11 || jtag_overrun !== 1'b0 || jtag_busy !== 1'b0) begin
            tests_failed++; $display("FAIL jwr_post: MonAReg %h overrun %b busy %b exp 11 0 0", MonAReg, jtag_overrun, jtag_busy);
        end
    endtask

    task automatic test_jtag_read();
        jdo = 38'h0; jdo[9:2] = 8'h10; jdo[35] = 1'b1; take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        tests_run++;
        if (jtag_busy !== 1'b1) begin
            tests_failed++; $display("FAIL jrd_busy: got %b exp 1", jtag_busy);
        end
        repeat (2) tick();
        tests_run++;
        if (MonDReg !== 32'hDEADBEEF || MonAReg !== 8'h11) begin
            tests_failed++; $display("FAIL jrd_a: MonDReg %h MonAReg %h exp deadbeef 11", MonDReg, MonAReg);
        end
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        repeat (2) tick();
        tests_run++;
        if (MonDReg !== 32'hCAFEF00D || MonAReg !== 8'h12 || jtag_busy !== 1'b0) begin
            tests_failed++; $display("FAIL jrd_noact: MonDReg %h MonAReg %h busy %b exp cafef00d 12 0", MonDReg, MonAReg, jtag_busy);
        end
    endtask

    task automatic test_wrap();
        jdo = 38'h0; jdo[9:2] = 8'hFF; take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        repeat (2) tick();
        tests_run++;
        if (MonDReg !== 32'h0BADF00D || MonAReg !== 8'h00) begin
            tests_failed++; $display("FAIL wrap: MonDReg %h MonAReg %h exp 0badf00d 00", MonDReg, MonAReg);
        end
    endtask

    task automatic test_contention();
        int lat;
        int exp_lat;
        logic done;
        logic [31:0] got;
`ifdef OCIMEM_RR_EN
        exp_lat = 2;
`else
        exp_lat = 4;
`endif
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        av_address = 8'h20; av_read = 1'b1;
        lat = 0; done = 1'b0; got = 32'h0;
        while (!done && lat < 20) begin
            lat++;
            #1;
            if (!av_waitrequest) begin
                done = 1'b1; got = av_readdata;
            end
            tick();
        end
        av_read = 1'b0;
        tests_run++;
        if (!done || lat !== exp_lat) begin
            tests_failed++; $display("FAIL contend_lat: got %0d done %b exp %0d", lat, done, exp_lat);
        end
        tests_run++;
        if (got !== 32'h12345678) begin
            tests_failed++; $display("FAIL contend_data: got %h exp 12345678", got);
        end
        repeat (4) tick();
        tests_run++;
        if (MonAReg !== 8'h01 || jtag_busy !== 1'b0) begin
            tests_failed++; $display("FAIL contend_jtag: MonAReg %h busy %b exp 01 0", MonAReg, jtag_busy);
        end
    endtask

    task automatic test_overrun();
        take_no_action_ocimem_a = 1'b1;
        repeat (2) tick();
        take_no_action_ocimem_a = 1'b0;
        repeat (4) tick();
        tests_run++;
        if (jtag_overrun !== 1'b1) begin
            tests_failed++; $display("FAIL overrun_flag: got %b exp 1", jtag_overrun);
        end
        tests_run++;
        if (MonAReg !== 8'h02 || jtag_busy !== 1'b0) begin
            tests_failed++; $display("FAIL overrun_incr: MonAReg %h busy %b exp 02 0", MonAReg, jtag_busy);
        end
    endtask

    task automatic test_reset_mid_read();
        av_address = 8'h20; av_read = 1'b1;
        tick();
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (av_waitrequest !== 1'b1 || av_readdata !== 32'h0) begin
            tests_failed++; $display("FAIL rst_mid_av: wait %b readdata %h exp 1 0", av_waitrequest, av_readdata);
        end
        tests_run++;
        if (MonAReg !== 8'h0 || MonDReg !== 32'h0 || jtag_overrun !== 1'b0 || jtag_busy !== 1'b0 || ram_wren !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_regs: MonAReg %h MonDReg %h overrun %b busy %b wren %b exp 0", MonAReg, MonDReg, jtag_overrun, jtag_busy, ram_wren);
        end
        av_read = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        av_wr(8'h30, 32'h55AA55AA, 1'b1);
        tests_run++;
        if (mem[8'h30] !== 32'h55AA55AA) begin
            tests_failed++; $display("FAIL rst_recover: ram %h exp 55aa55aa", mem[8'h30]);
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        reset_n = 1'b0; jdo = 38'h0;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
        av_address = 8'h0; av_read = 1'b0; av_write = 1'b0; av_writedata = 32'h0;
        av_byteenable = 4'hF; av_debugaccess = 1'b0;
        test_reset();
        test_avalon();
        test_jtag_write();
        test_jtag_read();
        test_wrap();
        test_contention();
        test_overrun();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
